// File: rtl/counter_monitor_pkg.sv
// Shared types and helpers for the counter monitor.
// Holds the lock FSM state encoding, default parameter values and the
// saturating increment used by the error counter.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH       = 64;
  localparam int unsigned DEF_ERR_CNT_W   = 16;
  localparam int unsigned DEF_SYNC_CYCLES = 2;

  // Working width of sat_inc; error counters up to this width are supported.
  localparam int unsigned SAT_W = 32;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    logic [SAT_W-1:0] res;
    if (val >= max_val) res = max_val;
    else                res = val + SAT_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/counter_monitor_snap.sv
// Snapshot capture for the counter monitor.
// Holds one captured counter value plus the error count at capture time and
// offers it on a valid/ready handshake. A request that arrives while an
// unaccepted snapshot is still pending is dropped and reported on snap_ovf_o.
// A request in the same cycle the pending snapshot is taken replaces it.
module counter_monitor_snap
  import counter_monitor_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     cnt_i,
  input  logic [ERR_CNT_W-1:0] err_cnt_i,
  input  logic                 snap_req_i,
  input  logic                 snap_ready_i,
  output logic                 snap_valid_o,
  output logic [WIDTH-1:0]     snap_data_o,
  output logic [ERR_CNT_W-1:0] snap_err_o,
  output logic                 snap_ovf_o
);

  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic [ERR_CNT_W-1:0] r_err;
  logic                 r_ovf;

  logic w_consume;
  logic w_accept;
  logic w_drop;

  assign w_consume = r_valid && snap_ready_i;
  assign w_accept  = snap_req_i && (!r_valid || snap_ready_i);
  assign w_drop    = snap_req_i && r_valid && !snap_ready_i;

  // Valid flag: set on capture, cleared once the consumer takes the snapshot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Capture register: only written on an accepted request, so data holds while pending.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_data <= '0;
      r_err  <= '0;
    end else if (w_accept) begin
      r_data <= cnt_i;
      r_err  <= err_cnt_i;
    end
  end

  // Overflow pulse for a request lost against a stalled snapshot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_drop;
    end
  end

  assign snap_valid_o = r_valid;
  assign snap_data_o  = r_data;
  assign snap_err_o   = r_err;
  assign snap_ovf_o   = r_ovf;

endmodule

// File: rtl/counter_monitor.sv
// Counter monitor: checks a free-running up-counter for clean +1 steps,
// locks after SYNC_CYCLES consecutive good increments, counts violations
// seen while locked, flags all-ones -> 0 wraps and serves snapshots.
// Build option COUNTER_MONITOR_STICKY_ERR_EN: when defined err_o is sticky
// until clr_i/reset, otherwise it is a one-cycle pulse per violation.
// ERR_CNT_W must not exceed SAT_W (32).
//
// state  | meaning
// IDLE   | counter held in reset (or just out of reset); nothing to compare yet
// SYNC   | counting consecutive good increments; violations are not errors
// LOCKED | sequence trusted; any bad increment is an error and forces resync
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ERR_CNT_W   = DEF_ERR_CNT_W,
  parameter int unsigned SYNC_CYCLES = DEF_SYNC_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [WIDTH-1:0]     cnt_i,
  input  logic                 cnt_rst_i,
  input  logic                 clr_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 wrap_o,
  input  logic                 snap_req_i,
  output logic                 snap_valid_o,
  input  logic                 snap_ready_i,
  output logic [WIDTH-1:0]     snap_data_o,
  output logic [ERR_CNT_W-1:0] snap_err_o,
  output logic                 snap_ovf_o
);

  localparam int unsigned SYNC_W = $clog2(SYNC_CYCLES + 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [WIDTH-1:0]     r_prev;
  logic [SYNC_W-1:0]    r_sync_cnt;
  logic [SYNC_W-1:0]    w_sync_cnt_nxt;
  logic [SYNC_W-1:0]    w_sync_inc;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [ERR_CNT_W-1:0] w_err_cnt_inc;
  logic                 r_err;
  logic                 r_locked;
  logic                 r_wrap;
  logic                 w_match;
  logic                 w_err_ev;
  logic                 w_wrap_ev;

  // Modular +1 so that all-ones followed by zero is a legal step.
  assign w_match    = (cnt_i == r_prev + WIDTH'(1));
  assign w_sync_inc = r_sync_cnt + SYNC_W'(1);
  assign w_wrap_ev  = (r_state != IDLE) && (r_prev == '1) && (cnt_i == '0);

  assign w_err_cnt_inc = ERR_CNT_W'(sat_inc(SAT_W'(r_err_cnt),
                                            SAT_W'({ERR_CNT_W{1'b1}})));

  // Next-state and error-event decode; upstream counter reset overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_sync_cnt_nxt = r_sync_cnt;
    w_err_ev       = 1'b0;
    if (cnt_rst_i) begin
      w_state_nxt    = IDLE;
      w_sync_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = SYNC;
          w_sync_cnt_nxt = '0;
        end
        SYNC: begin
          if (w_match) begin
            if (w_sync_inc == SYNC_W'(SYNC_CYCLES)) begin
              w_state_nxt    = LOCKED;
              w_sync_cnt_nxt = '0;
            end else begin
              w_sync_cnt_nxt = w_sync_inc;
            end
          end else begin
            w_sync_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!w_match) begin
            w_err_ev       = 1'b1;
            w_state_nxt    = SYNC;
            w_sync_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_sync_cnt_nxt = '0;
        end
      endcase
    end
  end

  // FSM state, previous sample, and the registered lock/wrap indications.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_sync_cnt <= '0;
      r_prev     <= '0;
      r_locked   <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync_cnt <= w_sync_cnt_nxt;
      r_prev     <= cnt_i;
      r_locked   <= (r_state == LOCKED);
      r_wrap     <= w_wrap_ev;
    end
  end

  // Error count and flag; a clear in the same cycle as an event wins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else if (clr_i) begin
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_err_ev) begin
        r_err_cnt <= w_err_cnt_inc;
      end
`ifdef COUNTER_MONITOR_STICKY_ERR_EN
      if (w_err_ev) begin
        r_err <= 1'b1;
      end
`else
      r_err <= w_err_ev;
`endif
    end
  end

  counter_monitor_snap #(
    .WIDTH     (WIDTH),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_snap (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cnt_i        (cnt_i),
    .err_cnt_i    (r_err_cnt),
    .snap_req_i   (snap_req_i),
    .snap_ready_i (snap_ready_i),
    .snap_valid_o (snap_valid_o),
    .snap_data_o  (snap_data_o),
    .snap_err_o   (snap_err_o),
    .snap_ovf_o   (snap_ovf_o)
  );

  assign locked_o  = r_locked;
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
  assign wrap_o    = r_wrap;

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench for counter_monitor (64-bit counter, 2-bit error
// counter so saturation is reachable, lock after 2 good increments).
`timescale 1ns/1ps
module tb_counter_monitor;

  localparam int W    = 64;
  localparam int EW   = 2;
  localparam int SC   = 2;
  localparam int EMAX = (1 << EW) - 1;
`ifdef COUNTER_MONITOR_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [W-1:0]  cnt_i = '0;
  logic          cnt_rst_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          locked_o;
  logic          err_o;
  logic [EW-1:0] err_cnt_o;
  logic          wrap_o;
  logic          snap_req_i = 1'b0;
  logic          snap_valid_o;
  logic          snap_ready_i = 1'b0;
  logic [W-1:0]  snap_data_o;
  logic [EW-1:0] snap_err_o;
  logic          snap_ovf_o;

  always #5 clk_i = ~clk_i;

  counter_monitor #(
    .WIDTH       (W),
    .ERR_CNT_W   (EW),
    .SYNC_CYCLES (SC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cnt_i        (cnt_i),
    .cnt_rst_i    (cnt_rst_i),
    .clr_i        (clr_i),
    .locked_o     (locked_o),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o),
    .wrap_o       (wrap_o),
    .snap_req_i   (snap_req_i),
    .snap_valid_o (snap_valid_o),
    .snap_ready_i (snap_ready_i),
    .snap_data_o  (snap_data_o),
    .snap_err_o   (snap_err_o),
    .snap_ovf_o   (snap_ovf_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: lock is "out of idle and at least SC good steps in a row".
  bit          m_idle = 1'b1;
  int          m_run = 0;
  logic [63:0] m_prev = '0;
  bit          m_locked = 0, m_err = 0, m_wrap = 0, m_sv = 0, m_ovf = 0;
  int          m_errcnt = 0, m_se = 0;
  logic [63:0] m_sd = '0;

  task automatic model_edge();
    bit good, in_lock, ev, acc;
    if (!rst_ni) begin
      m_idle = 1; m_run = 0; m_prev = '0;
      m_locked = 0; m_err = 0; m_wrap = 0; m_sv = 0; m_ovf = 0;
      m_errcnt = 0; m_se = 0; m_sd = '0;
    end else begin
      good    = (cnt_i == m_prev + 64'd1);
      in_lock = !m_idle && (m_run >= SC);
      ev      = in_lock && !cnt_rst_i && !good;
      m_locked = in_lock;
      m_wrap   = !m_idle && (m_prev == {64{1'b1}}) && (cnt_i == 64'd0);
      acc   = snap_req_i && (!m_sv || snap_ready_i);
      m_ovf = snap_req_i && m_sv && !snap_ready_i;
      if (acc) begin
        m_sd = cnt_i; m_se = m_errcnt; m_sv = 1;
      end else if (m_sv && snap_ready_i) begin
        m_sv = 0;
      end
      if (clr_i) begin
        m_errcnt = 0; m_err = 0;
      end else begin
        if (ev && m_errcnt < EMAX) m_errcnt++;
        m_err = STICKY ? (m_err || ev) : ev;
      end
      if (cnt_rst_i) begin
        m_idle = 1; m_run = 0;
      end else if (m_idle) begin
        m_idle = 0; m_run = 0;
      end else if (good) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 0;
      end
      m_prev = cnt_i;
    end
  endtask

  task automatic check_model();
    check("locked_o", 64'(locked_o), 64'(m_locked));
    check("err_o", 64'(err_o), 64'(m_err));
    check("err_cnt_o", 64'(err_cnt_o), 64'(m_errcnt));
    check("wrap_o", 64'(wrap_o), 64'(m_wrap));
    check("snap_valid_o", 64'(snap_valid_o), 64'(m_sv));
    check("snap_ovf_o", 64'(snap_ovf_o), 64'(m_ovf));
    if (m_sv) begin
      check("snap_data_o", snap_data_o, m_sd);
      check("snap_err_o", 64'(snap_err_o), 64'(m_se));
    end
  endtask

  task automatic step(input logic [63:0] cnt, input bit crst, input bit clr,
                      input bit req, input bit rdy);
    cnt_i = cnt; cnt_rst_i = crst; clr_i = clr; snap_req_i = req; snap_ready_i = rdy;
    @(posedge clk_i);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct {
    logic [63:0] cnt;
    bit          crst;
    bit          clr;
    bit          locked;
    int          errcnt;
    bit          err_p;
    bit          err_s;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [63:0] cnt, input bit crst, input bit clr, input bit locked,
                     input int errcnt, input bit err_p, input bit err_s);
    vec_t v;
    v.cnt = cnt; v.crst = crst; v.clr = clr; v.locked = locked;
    v.errcnt = errcnt; v.err_p = err_p; v.err_s = err_s;
    vq.push_back(v);
  endtask

  initial begin : main
    logic [63:0] ones;
    logic [63:0] c;
    logic [63:0] held;
    int          wraps;
    int          r;
    bit          crst, clr, req, rdy;

    ones = '1;

    // lock-up, violation/relock, clear, upstream reset with a sync-phase mismatch
    for (int i = 0; i <= 10; i++) add(64'(i), 0, 0, (i >= 3), 0, 0, 0);
    add(64'd12, 0, 0, 1, 1, 1, 1);
    add(64'd13, 0, 0, 0, 1, 0, 1);
    add(64'd14, 0, 0, 0, 1, 0, 1);
    add(64'd15, 0, 0, 1, 1, 0, 1);
    add(64'd16, 0, 1, 1, 0, 0, 0);
    add(64'd0,  1, 0, 1, 0, 0, 0);
    add(64'd1,  0, 0, 0, 0, 0, 0);
    add(64'd5,  0, 0, 0, 0, 0, 0);
    add(64'd6,  0, 0, 0, 0, 0, 0);
    add(64'd7,  0, 0, 0, 0, 0, 0);
    add(64'd8,  0, 0, 1, 0, 0, 0);

    // reset
    rst_ni = 1'b0;
    step(64'd55, 0, 0, 1, 0);
    step(64'd56, 1, 1, 1, 1);
    check("rst_locked", 64'(locked_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    check("rst_wrap", 64'(wrap_o), 64'd0);
    check("rst_snap_valid", 64'(snap_valid_o), 64'd0);
    check("rst_snap_data", snap_data_o, 64'd0);
    check("rst_snap_err", 64'(snap_err_o), 64'd0);
    check("rst_snap_ovf", 64'(snap_ovf_o), 64'd0);
    rst_ni = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].cnt, vq[i].crst, vq[i].clr, 0, 0);
      check($sformatf("tbl%0d_locked", i), 64'(locked_o), 64'(vq[i].locked));
      check($sformatf("tbl%0d_err_cnt", i), 64'(err_cnt_o), 64'(vq[i].errcnt));
      check($sformatf("tbl%0d_err", i), 64'(err_o), 64'(STICKY ? vq[i].err_s : vq[i].err_p));
      check($sformatf("tbl%0d_wrap", i), 64'(wrap_o), 64'd0);
    end

    // wrap through all-ones while locked
    step(64'd0, 1, 0, 0, 0);
    for (int k = 5; k >= 2; k--) step(ones - 64'(k), 0, 0, 0, 0);
    check("pre_wrap_locked", 64'(locked_o), 64'd1);
    wraps = 0;
    step(ones - 64'd1, 0, 0, 0, 0); wraps += int'(wrap_o);
    step(ones, 0, 0, 0, 0);         wraps += int'(wrap_o);
    step(64'd0, 0, 0, 0, 0);
    check("wrap_pulse_at_zero", 64'(wrap_o), 64'd1);
    wraps += int'(wrap_o);
    step(64'd1, 0, 0, 0, 0);        wraps += int'(wrap_o);
    step(64'd2, 0, 0, 0, 0);        wraps += int'(wrap_o);
    check("wrap_pulse_count", 64'(wraps), 64'd1);
    check("wrap_locked", 64'(locked_o), 64'd1);
    check("wrap_no_err", 64'(err_cnt_o), 64'd0);

    // snapshot hold, overflow drop, release
    step(64'd0, 1, 0, 0, 0);
    step(64'd97, 0, 0, 0, 0);
    step(64'd98, 0, 0, 0, 0);
    step(64'd99, 0, 0, 0, 0);
    step(64'd100, 0, 0, 1, 0);
    check("snap_valid_after_req", 64'(snap_valid_o), 64'd1);
    check("snap_data_100", snap_data_o, 64'd100);
    step(64'd101, 0, 0, 0, 0);
    step(64'd102, 0, 0, 1, 0);
    check("snap_ovf_pulse", 64'(snap_ovf_o), 64'd1);
    check("snap_data_held", snap_data_o, 64'd100);
    step(64'd103, 0, 0, 0, 0);
    check("snap_ovf_single", 64'(snap_ovf_o), 64'd0);
    check("snap_still_valid", 64'(snap_valid_o), 64'd1);
    step(64'd104, 0, 0, 0, 1);
    check("snap_released", 64'(snap_valid_o), 64'd0);

    // saturation of the error counter, then clear
    c = 64'd104;
    for (int v = 0; v < 5; v++) begin
      c += 64'd5;
      step(c, 0, 0, 0, 0);
      check($sformatf("sat_err_cnt_%0d", v), 64'(err_cnt_o), 64'((v + 1 < EMAX) ? v + 1 : EMAX));
      check($sformatf("sat_err_flag_%0d", v), 64'(err_o), 64'd1);
      c += 64'd1; step(c, 0, 0, 0, 0);
      c += 64'd1; step(c, 0, 0, 0, 0);
    end
    check("sat_err_cnt_final", 64'(err_cnt_o), 64'd3);
    check("err_after_gap", 64'(err_o), 64'(STICKY));
    c += 64'd1; step(c, 0, 1, 0, 0);
    check("clr_err_cnt", 64'(err_cnt_o), 64'd0);
    check("clr_err", 64'(err_o), 64'd0);
    c += 64'd10; step(c, 0, 1, 0, 0);
    check("clr_wins_cnt", 64'(err_cnt_o), 64'd0);
    check("clr_wins_err", 64'(err_o), 64'd0);
    c += 64'd1; step(c, 0, 0, 0, 0);
    c += 64'd1; step(c, 0, 0, 0, 0);
    c += 64'd1; step(c, 0, 0, 0, 0);

    // upstream reset while locked keeps a pending snapshot; replace-on-accept
    c += 64'd1; held = c; step(c, 0, 0, 1, 0);
    step(64'd0, 1, 0, 0, 0);
    check("crst_no_err", 64'(err_cnt_o), 64'd0);
    step(64'd1, 0, 0, 0, 0);
    check("crst_unlocked", 64'(locked_o), 64'd0);
    check("crst_snap_valid", 64'(snap_valid_o), 64'd1);
    check("crst_snap_data", snap_data_o, held);
    step(64'd2, 0, 0, 1, 1);
    check("replace_valid", 64'(snap_valid_o), 64'd1);
    check("replace_data", snap_data_o, 64'd2);
    check("replace_no_ovf", 64'(snap_ovf_o), 64'd0);
    step(64'd3, 0, 0, 0, 1);
    check("replace_released", 64'(snap_valid_o), 64'd0);

    // randomized traffic against the model
    c = 64'd3;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      crst = 0;
      if (r < 3) begin
        crst = 1; c = 64'd0;
      end else if (r < 8) begin
        c = {$urandom, $urandom};
      end else if (r < 11) begin
        c = ones - 64'($urandom_range(0, 3));
      end else begin
        c += 64'd1;
      end
      clr = ($urandom_range(0, 99) < 3);
      req = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 50);
      rst_ni = ($urandom_range(0, 499) != 0);
      step(c, crst, clr, req, rdy);
    end
    rst_ni = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
